// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types for the direct-mapped read cache and its refill sequencer.
// Holds the FSM encoding and the address-split helpers.
package cache_refill_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOOKUP  = 2'd1,
      REFILL  = 2'd2,
      RESPOND = 2'd3
   } state_t;

   // addr[1:0] selects a byte within a word and is never used
   localparam int BYTE_W = 2;

   function automatic int tag_width(input int addr_w,
                                    input int index_w,
                                    input int offset_w);
      return addr_w - index_w - offset_w - BYTE_W;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag, valid and data arrays of the cache.
// Combinational read; per-word write, tag+valid write, invalidate, flush-all.
module cache_line_store
   import cache_refill_ctrl_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int INDEX_W  = 4,
   parameter int OFFSET_W = 2,
   parameter int TAG_W    = 24
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [INDEX_W-1:0]  index,
   input  logic [OFFSET_W-1:0] rd_offset,
   output logic                rd_valid,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [DATA_W-1:0]   rd_data,
   input  logic                wr_en,
   input  logic [OFFSET_W-1:0] wr_offset,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                tag_we,
   input  logic [TAG_W-1:0]    wr_tag,
   input  logic                inv_en,
   input  logic                flush_all
);

   localparam int LINES = 2 ** INDEX_W;
   localparam int WORDS = 2 ** OFFSET_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags  [LINES];
   logic [DATA_W-1:0] words [LINES][WORDS];

   assign rd_valid = valid[index];
   assign rd_tag   = tags[index];
   assign rd_data  = words[index][rd_offset];

   // valid bits: flush beats invalidate beats line completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valid <= '0;
      else if (flush_all)
         valid <= '0;
      else if (inv_en)
         valid[index] <= 1'b0;
      else if (tag_we)
         valid[index] <= 1'b1;
   end

   // payload arrays need no reset; valid gates every use
   always_ff @(posedge clk) begin
      if (wr_en)
         words[index][wr_offset] <= wr_data;
      if (tag_we)
         tags[index] <= wr_tag;
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped read-only cache controller: lookup, line refill, response.
// All outputs registered; hit/miss counters saturate.
module cache_refill_ctrl
   import cache_refill_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int INDEX_W  = 4,
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
   localparam int WA_W   = ADDR_W - BYTE_W;
   localparam int LINE_W = WA_W - OFFSET_W;
   localparam logic [OFFSET_W-1:0] LAST = '1;

   state_t state, state_n;

   logic [WA_W-1:0]     req_addr, req_addr_n;
   logic [OFFSET_W-1:0] beat, beat_n, beat_inc;
   logic                flush_pend, flush_pend_n;
   logic                ready_n, hit_n, mem_req_n;
   logic [DATA_W-1:0]   rdata_n;
   logic [ADDR_W-1:0]   mem_addr_n;
   logic [CNT_W-1:0]    hits_n, misses_n;
   logic                st_wr, st_tag_we, st_inv, st_flush;
   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [DATA_W-1:0]   rd_data;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_offset;
   logic [TAG_W-1:0]    req_tag;
   logic [LINE_W-1:0]   req_line;
   logic                unused_byte_bits;

   assign req_offset = req_addr[OFFSET_W-1:0];
   assign req_index  = req_addr[OFFSET_W +: INDEX_W];
   assign req_tag    = req_addr[WA_W-1 -: TAG_W];
   assign req_line   = req_addr[WA_W-1:OFFSET_W];
   assign beat_inc   = beat + OFFSET_W'(1);

   assign unused_byte_bits = ^cpu_addr[BYTE_W-1:0];

   cache_line_store #(
      .DATA_W   (DATA_W),
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W),
      .TAG_W    (TAG_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .index     (req_index),
      .rd_offset (req_offset),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (st_wr),
      .wr_offset (beat),
      .wr_data   (mem_rdata),
      .tag_we    (st_tag_we),
      .wr_tag    (req_tag),
      .inv_en    (st_inv),
      .flush_all (st_flush)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // next state, next output values and line-store controls
   always_comb begin
      state_n      = state;
      req_addr_n   = req_addr;
      beat_n       = beat;
      flush_pend_n = flush_pend | flush;
      ready_n      = 1'b0;
      hit_n        = 1'b0;
      rdata_n      = cpu_rdata;
      mem_req_n    = mem_req;
      mem_addr_n   = mem_addr;
      hits_n       = hit_count;
      misses_n     = miss_count;
      st_wr        = 1'b0;
      st_tag_we    = 1'b0;
      st_inv       = 1'b0;
      st_flush     = 1'b0;
      unique case (state)
         IDLE: begin
            if (flush || flush_pend) begin
               st_flush     = 1'b1;
               flush_pend_n = 1'b0;
            end else if (cpu_req && !cpu_ready) begin
               req_addr_n = cpu_addr[ADDR_W-1:BYTE_W];
               state_n    = LOOKUP;
            end
         end
         LOOKUP: begin
            if (rd_valid && rd_tag == req_tag) begin
               ready_n = 1'b1;
               hit_n   = 1'b1;
               rdata_n = rd_data;
               if (!(&hit_count))
                  hits_n = hit_count + CNT_W'(1);
               state_n = IDLE;
            end else begin
               st_inv     = 1'b1;
               if (!(&miss_count))
                  misses_n = miss_count + CNT_W'(1);
               beat_n     = '0;
               mem_req_n  = 1'b1;
               mem_addr_n = {req_line, {OFFSET_W{1'b0}}, 2'b00};
               state_n    = REFILL;
            end
         end
         REFILL: begin
            if (mem_valid) begin
               st_wr      = 1'b1;
               beat_n     = beat_inc;
               mem_addr_n = {req_line, beat_inc, 2'b00};
               if (beat == LAST) begin
                  st_tag_we = 1'b1;
                  mem_req_n = 1'b0;
                  state_n   = RESPOND;
               end
            end
         end
         RESPOND: begin
            ready_n = 1'b1;
            rdata_n = rd_data;
            state_n = IDLE;
         end
      endcase
   end

   // registered outputs and datapath state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr   <= '0;
         beat       <= '0;
         flush_pend <= 1'b0;
         cpu_ready  <= 1'b0;
         cpu_hit    <= 1'b0;
         cpu_rdata  <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         busy       <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         req_addr   <= req_addr_n;
         beat       <= beat_n;
         flush_pend <= flush_pend_n;
         cpu_ready  <= ready_n;
         cpu_hit    <= hit_n;
         cpu_rdata  <= rdata_n;
         mem_req    <= mem_req_n;
         mem_addr   <= mem_addr_n;
         busy       <= (state_n != IDLE);
         hit_count  <= hits_n;
         miss_count <= misses_n;
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus
// random reads against an abstract cache/memory model.
module tb_cache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        cpu_hit;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        busy;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int total = 0;
   int bad   = 0;

   // abstract model: which line holds which tag, plus access totals
   bit          mv [16];
   logic [23:0] mt [16];
   int          mh;
   int          mm;

   logic [31:0] seen [$];

   cache_refill_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_ready  (cpu_ready),
      .cpu_rdata  (cpu_rdata),
      .cpu_hit    (cpu_hit),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   // backing memory contents
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a[31:4] == 28'h4)
         return 32'hA0 + {30'd0, a[3:2]};
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   function automatic void model_reset();
      foreach (mv[i]) mv[i] = 1'b0;
      mh = 0;
      mm = 0;
   endfunction

   function automatic void model_flush();
      foreach (mv[i]) mv[i] = 1'b0;
   endfunction

   // returns 1 on a hit; a miss makes the line resident
   function automatic bit model_access(input logic [31:0] a);
      logic [3:0]  ix = a[7:4];
      logic [23:0] tg = a[31:8];
      if (mv[ix] && mt[ix] == tg) begin
         mh++;
         return 1'b1;
      end
      mv[ix] = 1'b1;
      mt[ix] = tg;
      mm++;
      return 1'b0;
   endfunction

   // expected beat addresses, beat sb repeated while stalled sn cycles
   function automatic bit seq_ok(input logic [31:0] a, input int sb, input int sn);
      logic [31:0] e [$];
      for (int b = 0; b < 4; b++)
         for (int k = 0; k <= ((b == sb) ? sn : 0); k++)
            e.push_back({a[31:4], 2'(b), 2'b00});
      if (e.size() != seen.size()) return 1'b0;
      foreach (e[i])
         if (e[i] !== seen[i]) return 1'b0;
      return 1'b1;
   endfunction

   // one CPU read with memory responder; fc = cycle to pulse flush
   task automatic read_txn(input logic [31:0] a, input int sb, input int sn,
                           input int fc, output logic [31:0] rd,
                           output logic hit, output int lat,
                           output bit to, output bit fl);
      int beat = 0;
      int st = 0;
      seen.delete();
      to = 1'b1;
      fl = 1'b0;
      lat = 0;
      rd = '0;
      hit = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_addr = a;
      mem_valid = 1'b0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         lat = c;
         flush = 1'b0;
         if (cpu_ready) begin
            rd = cpu_rdata;
            hit = cpu_hit;
            to = 1'b0;
            break;
         end
         if (c == fc) begin
            flush = 1'b1;
            fl = 1'b1;
         end
         mem_valid = 1'b0;
         if (mem_req) begin
            seen.push_back(mem_addr);
            if (beat == sb && st < sn) begin
               st++;
            end else begin
               mem_rdata = memword(mem_addr);
               mem_valid = 1'b1;
               beat++;
            end
         end
      end
      cpu_req = 1'b0;
      mem_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if ({cpu_ready, cpu_hit, mem_req, busy} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b want=0000", {cpu_ready, cpu_hit, mem_req, busy});
      end
      total++;
      if ({cpu_rdata, mem_addr} !== 64'd0) begin
         bad++;
         $display("FAIL reset_data got rdata=%h addr=%h want 0", cpu_rdata, mem_addr);
      end
      total++;
      if ({hit_count, miss_count} !== 64'd0) begin
         bad++;
         $display("FAIL reset_counts got h=%0d m=%0d want 0", hit_count, miss_count);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_first_miss();
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      read_txn(32'h40, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h40));
      total++;
      if (to || lat !== 7) begin
         bad++;
         $display("FAIL miss_latency got=%0d to=%0b want=7", lat, to);
      end
      total++;
      if (!seq_ok(32'h40, 9, 0)) begin
         bad++;
         $display("FAIL miss_beats got n=%0d want 40,44,48,4C", seen.size());
      end
      total++;
      if (rd !== 32'hA0 || hit !== 1'b0) begin
         bad++;
         $display("FAIL miss_resp got rd=%h hit=%b want A0/0", rd, hit);
      end
      total++;
      if (miss_count !== 32'd1) begin
         bad++;
         $display("FAIL miss_count got=%0d want=1", miss_count);
      end
   endtask

   task automatic test_hit();
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      read_txn(32'h48, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h48));
      total++;
      if (lat !== 2 || to) begin
         bad++;
         $display("FAIL hit_latency got=%0d want=2", lat);
      end
      total++;
      if (rd !== 32'hA2 || hit !== 1'b1) begin
         bad++;
         $display("FAIL hit_resp got rd=%h hit=%b want A2/1", rd, hit);
      end
      total++;
      if (seen.size() !== 0 || hit_count !== 32'd1) begin
         bad++;
         $display("FAIL hit_nomem got beats=%0d hits=%0d want 0/1", seen.size(), hit_count);
      end
   endtask

   task automatic test_conflict();
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      read_txn(32'h140, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h140));
      total++;
      if (hit !== 1'b0 || rd !== memword(32'h140)) begin
         bad++;
         $display("FAIL conflict_a got rd=%h hit=%b want %h/0", rd, hit, memword(32'h140));
      end
      read_txn(32'h40, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h40));
      total++;
      if (hit !== 1'b0 || rd !== 32'hA0 || !seq_ok(32'h40, 9, 0)) begin
         bad++;
         $display("FAIL conflict_b got rd=%h hit=%b want A0/0", rd, hit);
      end
      total++;
      if (miss_count !== 32'd3) begin
         bad++;
         $display("FAIL conflict_count got=%0d want=3", miss_count);
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      read_txn(32'h140, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h140));
      read_txn(32'h4C, 2, 3, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h4C));
      total++;
      if (!seq_ok(32'h4C, 2, 3)) begin
         bad++;
         $display("FAIL stall_beats got n=%0d want 7 with 0x48 held", seen.size());
      end
      total++;
      if (lat !== 10 || rd !== 32'hA3 || hit !== 1'b0) begin
         bad++;
         $display("FAIL stall_resp got lat=%0d rd=%h want 10/A3", lat, rd);
      end
      read_txn(32'h44, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h44));
      total++;
      if (rd !== 32'hA1 || hit !== 1'b1) begin
         bad++;
         $display("FAIL stall_line got rd=%h hit=%b want A1/1", rd, hit);
      end
   endtask

   task automatic test_flush_refill();
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      read_txn(32'h3C0, 9, 0, 4, rd, hit, lat, to, fl);
      void'(model_access(32'h3C0));
      model_flush();
      total++;
      if (lat !== 7 || rd !== memword(32'h3C0) || hit !== 1'b0) begin
         bad++;
         $display("FAIL flush_resp got lat=%0d rd=%h hit=%b", lat, rd, hit);
      end
      read_txn(32'h3C0, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(32'h3C0));
      total++;
      if (hit !== 1'b0 || lat !== 7 || rd !== memword(32'h3C0)) begin
         bad++;
         $display("FAIL flush_remiss got hit=%b lat=%0d want 0/7", hit, lat);
      end
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] a = 32'h5D0;
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      int beats = 0;
      bit got = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_addr = a;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         mem_valid = 1'b0;
         if (mem_req) begin
            if (beats == 2) begin
               got = 1'b1;
               break;
            end
            mem_rdata = memword(mem_addr);
            mem_valid = 1'b1;
            beats++;
         end
      end
      total++;
      if (!got || mem_addr !== 32'h5D8 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_reach got=%0b addr=%h busy=%b want 1/5D8/1", got, mem_addr, busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_drop got req=%b busy=%b want 0/0", mem_req, busy);
      end
      total++;
      if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
         bad++;
         $display("FAIL rstmid_counts got h=%0d m=%0d want 0", hit_count, miss_count);
      end
      cpu_req = 1'b0;
      mem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      read_txn(a, 9, 0, -1, rd, hit, lat, to, fl);
      void'(model_access(a));
      total++;
      if (hit !== 1'b0 || !seq_ok(a, 9, 0) || rd !== memword(a)) begin
         bad++;
         $display("FAIL rstmid_reread got hit=%b rd=%h want 0/%h", hit, rd, memword(a));
      end
      total++;
      if (miss_count !== 32'd1) begin
         bad++;
         $display("FAIL rstmid_miss got=%0d want=1", miss_count);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, rd;
      logic hit;
      int lat, sb, sn, fc;
      bit to, fl, eh;
      for (int n = 0; n < 60; n++) begin
         a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         a[31:24] = 8'h01;
         sb = $urandom_range(0, 3);
         sn = $urandom_range(0, 2);
         fc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : -1;
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            model_flush();
         end
         read_txn(a, sb, sn, fc, rd, hit, lat, to, fl);
         eh = model_access(a);
         if (fl) model_flush();
         total++;
         if (to || hit !== eh || rd !== memword({a[31:2], 2'b00})) begin
            bad++;
            $display("FAIL rand_resp a=%h got rd=%h hit=%b want %h/%b",
                     a, rd, hit, memword({a[31:2], 2'b00}), eh);
         end
         total++;
         if (lat !== (eh ? 2 : 7 + sn)) begin
            bad++;
            $display("FAIL rand_latency a=%h got=%0d want=%0d", a, lat, eh ? 2 : 7 + sn);
         end
         total++;
         if (eh ? (seen.size() != 0) : !seq_ok(a, sb, sn)) begin
            bad++;
            $display("FAIL rand_beats a=%h got n=%0d", a, seen.size());
         end
         total++;
         if (hit_count !== 32'(mh) || miss_count !== 32'(mm)) begin
            bad++;
            $display("FAIL rand_counts got h=%0d m=%0d want h=%0d m=%0d",
                     hit_count, miss_count, mh, mm);
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] rd;
      logic hit;
      int lat;
      bit to, fl;
      read_txn(32'h40, 9, 0, -1, rd, hit, lat, to, fl);
      @(negedge clk);
      force dut.hit_count = 32'hFFFF_FFFE;
      #1;
      release dut.hit_count;
      for (int k = 0; k < 3; k++) begin
         read_txn(32'h44, 9, 0, -1, rd, hit, lat, to, fl);
         total++;
         if (hit !== 1'b1 || rd !== 32'hA1) begin
            bad++;
            $display("FAIL sat_hit k=%0d got hit=%b rd=%h want 1/A1", k, hit, rd);
         end
         total++;
         if (hit_count !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL sat_count k=%0d got=%h want=FFFFFFFF", k, hit_count);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      cpu_req = 1'b0;
      cpu_addr = '0;
      flush = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      test_first_miss();
      test_hit();
      test_conflict();
      test_stall();
      test_flush_refill();
      test_reset_mid_refill();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
